// File: rtl/cdc_pkg.sv
// Shared definitions for the multi-bit level synchroniser: per-channel pulse
// modes and the helper that decides whether a level change raises a pulse.
package cdc_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_ANY  = 2'b11;

    // Called only when the filtered level actually changes; new_level is its new value.
    function automatic logic edge_pulse(input logic [1:0] mode, input logic new_level);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_NONE: r = 1'b0;
            MODE_RISE: r = new_level;
            MODE_FALL: r = ~new_level;
            MODE_ANY:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_chan.sv
// One synchroniser channel: flop chain, glitch-filter counter, filtered level
// and an optional one-cycle edge pulse, all reset asynchronously by RST (low).
module cdc_sync_chan
    import cdc_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   FILTER_LEN = 1,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       async_i,
    input  logic [1:0] mode_i,
    output logic       sync_o,
    output logic       pulse_o
);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("cdc_sync_chan: NUM_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("cdc_sync_chan: FILTER_LEN must be at least 1");
    end

    localparam int               CNT_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [NUM_STAGES-1:0] chain_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sync_q, sync_d;
    logic                  pulse_q, pulse_d;
    logic                  synced;

    assign synced = chain_q[NUM_STAGES-1];

    // Any sample that agrees with the current level restarts the qualification.
    always_comb begin
        cnt_d   = '0;
        sync_d  = sync_q;
        pulse_d = 1'b0;
        if (synced != sync_q) begin
            if (cnt_q == CNT_LAST) begin
                sync_d  = synced;
                pulse_d = edge_pulse(mode_i, synced);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_q <= {NUM_STAGES{RST_VAL}};
            cnt_q   <= '0;
            sync_q  <= RST_VAL;
            pulse_q <= 1'b0;
        end else begin
            chain_q <= {chain_q[NUM_STAGES-2:0], async_i};
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign sync_o  = sync_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/cdc_multi_sync.sv
// Multi-bit level synchroniser: BUS_WIDTH independent channels, each with its
// own flop chain, glitch filter and run-time selectable edge pulse.
module cdc_multi_sync
    import cdc_pkg::*;
#(
    parameter int                   NUM_STAGES = 2,
    parameter int                   BUS_WIDTH  = 8,
    parameter int                   FILTER_LEN = 1,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [BUS_WIDTH-1:0]   ASYNC,
    input  logic [2*BUS_WIDTH-1:0] MODE,
    output logic [BUS_WIDTH-1:0]   SYNC,
    output logic [BUS_WIDTH-1:0]   PULSE
);

    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("cdc_multi_sync: BUS_WIDTH must be at least 1");
    end

    // Channels share nothing but clock and reset; no bus coherency is implied.
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        cdc_sync_chan #(
            .NUM_STAGES (NUM_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RST_VAL    (RST_VAL[i])
        ) u_chan (
            .CLK     (CLK),
            .RST     (RST),
            .async_i (ASYNC[i]),
            .mode_i  (MODE[2*i +: 2]),
            .sync_o  (SYNC[i]),
            .pulse_o (PULSE[i])
        );
    end

endmodule

// File: tb/tb_cdc_multi_sync.sv
// Bench for cdc_multi_sync: three instances (defaults, FILTER_LEN=4,
// RST_VAL=8'hFF) checked against a sample-history reference model.
module tb_cdc_multi_sync;

    localparam int              NS = 2;
    localparam int              FL [3] = '{1, 4, 1};
    localparam logic [7:0]      RV [3] = '{8'h00, 8'h00, 8'hFF};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  async_v [3];
    logic [15:0] mode_v  [3];
    wire  [7:0]  sync_o  [3];
    wire  [7:0]  pulse_o [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdc_multi_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .FILTER_LEN(1), .RST_VAL(8'h00)) dut_a (
        .CLK(clk), .RST(rst_n), .ASYNC(async_v[0]), .MODE(mode_v[0]), .SYNC(sync_o[0]), .PULSE(pulse_o[0]));
    cdc_multi_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .FILTER_LEN(4), .RST_VAL(8'h00)) dut_f (
        .CLK(clk), .RST(rst_n), .ASYNC(async_v[1]), .MODE(mode_v[1]), .SYNC(sync_o[1]), .PULSE(pulse_o[1]));
    cdc_multi_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .FILTER_LEN(1), .RST_VAL(8'hFF)) dut_r (
        .CLK(clk), .RST(rst_n), .ASYNC(async_v[2]), .MODE(mode_v[2]), .SYNC(sync_o[2]), .PULSE(pulse_o[2]));

    // Reference model: the synced sample is the input seen NS edges ago (RST_VAL
    // before that much history exists); the level moves after FL consecutive
    // samples that disagree with it, pulsing according to the channel mode.
    logic [7:0] hist [3][$];
    logic [7:0] m_sync  [3];
    logic [7:0] m_pulse [3];
    int         run [3][8];

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] s;
        int n;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                hist[d].delete();
                m_sync[d]  = RV[d];
                m_pulse[d] = 8'h00;
                for (int i = 0; i < 8; i++) run[d][i] = 0;
            end else begin
                n = hist[d].size();
                s = (n >= NS) ? hist[d][n-NS] : RV[d];
                hist[d].push_back(async_v[d]);
                if (hist[d].size() > NS) void'(hist[d].pop_front());
                m_pulse[d] = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (s[i] == m_sync[d][i]) begin
                        run[d][i] = 0;
                    end else begin
                        run[d][i] = run[d][i] + 1;
                        if (run[d][i] == FL[d]) begin
                            m_sync[d][i] = s[i];
                            run[d][i] = 0;
                            case (mode_v[d][2*i +: 2])
                                2'b01:   m_pulse[d][i] = s[i];
                                2'b10:   m_pulse[d][i] = ~s[i];
                                2'b11:   m_pulse[d][i] = 1'b1;
                                default: m_pulse[d][i] = 1'b0;
                            endcase
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sync_o[d] !== RV[d]) begin
                errors++;
                $display("FAIL reset_sync dut%0d: got %h expected %h", d, sync_o[d], RV[d]);
            end
            checks++;
            if (pulse_o[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_pulse dut%0d: got %h expected 00", d, pulse_o[d]);
            end
        end
    endtask

    // Release with dut_r's inputs opposite its reset value, fall pulse on channel 0.
    task automatic test_rst_val;
        logic [7:0] exp_s [4];
        logic [7:0] exp_p [4];
        exp_s = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        exp_p = '{8'h00, 8'h00, 8'h01, 8'h00};
        mode_v[2] = 16'h0002;
        rst_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick(1);
            checks++;
            if (sync_o[2] !== exp_s[e]) begin
                errors++;
                $display("FAIL rst_val_sync edge%0d: got %h expected %h", e + 1, sync_o[2], exp_s[e]);
            end
            checks++;
            if (pulse_o[2] !== exp_p[e]) begin
                errors++;
                $display("FAIL rst_val_pulse edge%0d: got %h expected %h", e + 1, pulse_o[2], exp_p[e]);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp_s [3];
        exp_s = '{8'h00, 8'h00, 8'hA5};
        mode_v[0] = 16'h0000;
        async_v[0] = 8'hA5;
        for (int e = 0; e < 3; e++) begin
            tick(1);
            checks++;
            if (sync_o[0] !== exp_s[e]) begin
                errors++;
                $display("FAIL basic_sync edge%0d: got %h expected %h", e + 1, sync_o[0], exp_s[e]);
            end
            checks++;
            if (pulse_o[0] !== 8'h00) begin
                errors++;
                $display("FAIL basic_pulse edge%0d: got %h expected 00", e + 1, pulse_o[0]);
            end
        end
    endtask

    task automatic test_filter;
        async_v[1][0] = 1'b1;
        tick(3);
        async_v[1][0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick(1);
            checks++;
            if (sync_o[1][0] !== 1'b0) begin
                errors++;
                $display("FAIL filter_glitch cycle%0d: got %b expected 0", e, sync_o[1][0]);
            end
        end
        async_v[1][0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            checks++;
            if (sync_o[1][0] !== (e >= NS + 4)) begin
                errors++;
                $display("FAIL filter_qualify edge%0d: got %b expected %b", e, sync_o[1][0], e >= NS + 4);
            end
        end
    endtask

    task automatic test_pulse;
        logic [15:0] modes [3];
        int          exp_n [3];
        int          n_pulse, n_wide;
        logic        prev;
        modes = '{16'hFFFF, 16'h0040, 16'h0080};
        exp_n = '{4, 2, 2};
        for (int m = 0; m < 3; m++) begin
            mode_v[0] = modes[m];
            n_pulse = 0;
            n_wide  = 0;
            prev    = 1'b0;
            for (int t = 0; t < 4; t++) begin
                async_v[0][3] = ~async_v[0][3];
                for (int c = 0; c < 10; c++) begin
                    tick(1);
                    if (pulse_o[0][3] === 1'b1) n_pulse++;
                    if (pulse_o[0][3] === 1'b1 && prev) n_wide++;
                    prev = pulse_o[0][3];
                    checks++;
                    if (pulse_o[0] !== m_pulse[0]) begin
                        errors++;
                        $display("FAIL pulse_model mode%h: got %h expected %h", modes[m], pulse_o[0], m_pulse[0]);
                    end
                end
            end
            checks++;
            if (n_pulse != exp_n[m]) begin
                errors++;
                $display("FAIL pulse_count mode%h: got %0d expected %0d", modes[m], n_pulse, exp_n[m]);
            end
            checks++;
            if (n_wide != 0) begin
                errors++;
                $display("FAIL pulse_width mode%h: got %0d wide expected 0", modes[m], n_wide);
            end
        end
    endtask

    task automatic test_mode_change;
        tick(4);
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 3; d++) mode_v[d] = 16'($urandom);
            tick(1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pulse_o[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL mode_change dut%0d: got %h expected 00", d, pulse_o[d]);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        async_v[1][1] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sync_o[d] !== RV[d] || pulse_o[d] !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got sync %h pulse %h expected %h 00", d, sync_o[d], pulse_o[d], RV[d]);
            end
        end
        tick(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            checks++;
            if (sync_o[1] !== ((e >= NS + 4) ? 8'h03 : 8'h00)) begin
                errors++;
                $display("FAIL mid_reset_requal edge%0d: got %h expected %h", e, sync_o[1], (e >= NS + 4) ? 8'h03 : 8'h00);
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < 3; d++) begin
                async_v[d] = async_v[d] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
                if ($urandom_range(0, 15) == 0) mode_v[d] = 16'($urandom);
            end
            tick(1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (sync_o[d] !== m_sync[d]) begin
                    errors++;
                    $display("FAIL random_sync dut%0d cycle%0d: got %h expected %h", d, c, sync_o[d], m_sync[d]);
                end
                checks++;
                if (pulse_o[d] !== m_pulse[d]) begin
                    errors++;
                    $display("FAIL random_pulse dut%0d cycle%0d: got %h expected %h", d, c, pulse_o[d], m_pulse[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            async_v[d] = 8'h00;
            mode_v[d]  = 16'h0000;
        end
        test_reset();
        test_rst_val();
        test_basic();
        test_filter();
        test_pulse();
        test_mode_change();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
